// File: rtl/simd_alu_pipelined_acc_pkg.sv
// Shared encodings and group-width helper for the pipelined SIMD post-adder ALU.
package alu_simd_pkg;

  localparam logic [1:0] SIMD_ONE  = 2'b00;
  localparam logic [1:0] SIMD_TWO  = 2'b01;
  localparam logic [1:0] SIMD_FOUR = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b1100;
  localparam logic [3:0] ALU_OR  = 4'b1101;

  function automatic int unsigned group_width(input logic [1:0] mode, input int unsigned n);
    case (mode)
      SIMD_TWO:  return n / 2;
      SIMD_FOUR: return n / 4;
      default:   return n;
    endcase
  endfunction

endpackage

// File: rtl/simd_alu_pipelined_acc_lane_slice.sv
// One lane of the four-operand adder; the 2-bit carry covers four operands plus carry-in.
module simd_lane_slice
  import alu_simd_pkg::*;
#(
  parameter int unsigned LANE_W = 12
) (
  input  logic [LANE_W-1:0] w,
  input  logic [LANE_W-1:0] x,
  input  logic [LANE_W-1:0] y,
  input  logic [LANE_W-1:0] z,
  input  logic [1:0]        cin,
  input  logic [1:0]        carry_in,
  input  logic              brk,
  output logic [LANE_W-1:0] r,
  output logic [1:0]        cout
);

  localparam int unsigned SW = LANE_W + 2;

  logic [1:0]    ci;
  logic [SW-1:0] sum;

  always_comb begin
    ci  = brk ? cin : carry_in;
    sum = SW'(w) + SW'(x) + SW'(y) + SW'(z) + SW'(ci);
  end

  assign r    = sum[LANE_W-1:0];
  assign cout = sum[SW-1:LANE_W];

endmodule

// File: rtl/simd_alu_pipelined_acc.sv
// Two-stage SIMD post-adder ALU with P-register accumulate and per-beat grouping modes.
module simd_alu_pipelined_acc
  import alu_simd_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [3:0]              ALUMODE,
  input  logic [1:0]              SIMD_MODE,
  input  logic                    ACC_EN,
  input  logic                    CIN,
  input  logic [LANES*LANE_W-1:0] W,
  input  logic [LANES*LANE_W-1:0] Z,
  input  logic [LANES*LANE_W-1:0] Y,
  input  logic [LANES*LANE_W-1:0] X,
  output logic                    out_valid,
  output logic [LANES*LANE_W-1:0] S,
  output logic [3:0]              COUT,
  output logic                    illegal
);

  localparam int unsigned N        = LANES * LANE_W;
  localparam int unsigned LPG_TWO  = group_width(SIMD_TWO, N) / LANE_W;
  localparam int unsigned LPG_FOUR = group_width(SIMD_FOUR, N) / LANE_W;

  logic         v1;
  logic [N-1:0] w_q, z_q, y_q, x_q;
  logic         cin_q, acc_q;
  logic [3:0]   alu_q;
  logic [1:0]   simd_q;
  logic [N-1:0] p;

  logic [N-1:0]     zeff, wop, xop, yop, lane_sum, res;
  logic             is_sub, is_arith, bad;
  logic [1:0]       gcin;
  logic [LANES-1:0] brk, flag;
  logic [1:0]       lane_co [LANES];
  logic [3:0]       cout_c;

  // Stage 1: operand and control capture
  always_ff @(posedge clk) begin
    if (reset) begin
      v1     <= 1'b0;
      w_q    <= '0;
      z_q    <= '0;
      y_q    <= '0;
      x_q    <= '0;
      cin_q  <= 1'b0;
      acc_q  <= 1'b0;
      alu_q  <= '0;
      simd_q <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        w_q    <= W;
        z_q    <= Z;
        y_q    <= Y;
        x_q    <= X;
        cin_q  <= CIN;
        acc_q  <= ACC_EN;
        alu_q  <= ALUMODE;
        simd_q <= SIMD_MODE;
      end
    end
  end

  // Subtract is Zeff + ~W + ~X + ~Y + (3 - CIN); group carry of 3 means no borrow
  always_comb begin
    zeff     = acc_q ? p : z_q;
    is_sub   = (alu_q == ALU_SUB);
    is_arith = (alu_q == ALU_ADD) || is_sub;
    wop      = is_sub ? ~w_q : w_q;
    xop      = is_sub ? ~x_q : x_q;
    yop      = is_sub ? ~y_q : y_q;
    gcin     = is_sub ? (cin_q ? 2'd2 : 2'd3) : {1'b0, cin_q};
  end

  always_comb begin
    brk = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      case (simd_q)
        SIMD_TWO:  brk[i] = (i % LPG_TWO) == 0;
        SIMD_FOUR: brk[i] = (i % LPG_FOUR) == 0;
        default:   brk[i] = (i == 0);
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [1:0] carry_in;
    if (i == 0) begin : g_first
      assign carry_in = 2'b00;
    end else begin : g_chain
      assign carry_in = lane_co[i-1];
    end
    simd_lane_slice #(.LANE_W(LANE_W)) u_slice (
      .w        (wop[i*LANE_W +: LANE_W]),
      .x        (xop[i*LANE_W +: LANE_W]),
      .y        (yop[i*LANE_W +: LANE_W]),
      .z        (zeff[i*LANE_W +: LANE_W]),
      .cin      (gcin),
      .carry_in (carry_in),
      .brk      (brk[i]),
      .r        (lane_sum[i*LANE_W +: LANE_W]),
      .cout     (lane_co[i])
    );
  end

  // Group flag taken from the top lane of each group
  always_comb begin
    flag   = '0;
    cout_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      flag[i] = is_sub ? (&lane_co[i]) : lane_co[i][0];
      case (simd_q)
        SIMD_TWO:  if (((i + 1) % LPG_TWO) == 0) cout_c[2'(i / LPG_TWO)] = flag[i];
        SIMD_FOUR: if (((i + 1) % LPG_FOUR) == 0) cout_c[2'(i / LPG_FOUR)] = flag[i];
        default:   if (i == LANES - 1) cout_c[0] = flag[i];
      endcase
    end
    if (!is_arith) cout_c = '0;
  end

  always_comb begin
    res = p;
    bad = 1'b0;
    case (alu_q)
      ALU_ADD, ALU_SUB: res = lane_sum;
      ALU_XOR:          res = x_q ^ zeff;
      ALU_AND:          res = x_q & zeff;
      ALU_OR:           res = x_q | zeff;
      default:          bad = 1'b1;
    endcase
    if (simd_q == 2'b11) bad = 1'b1;
  end

  // Stage 2: P/flags update; illegal beats leave P and COUT untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      p         <= '0;
      COUT      <= '0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        illegal <= bad;
        if (!bad) begin
          p    <= res;
          COUT <= cout_c;
        end
      end
    end
  end

  assign S = p;

endmodule

// File: tb/tb_simd_alu_pipelined_acc.sv
// Scoreboard bench: vector table plus reference-model driven sequences for the SIMD ALU.
module tb_simd_alu_pipelined_acc;

  localparam int unsigned N = 48;

  logic         clk = 1'b0;
  logic         reset, in_valid, ACC_EN, CIN;
  logic [3:0]   ALUMODE;
  logic [1:0]   SIMD_MODE;
  logic [N-1:0] W, Z, Y, X;
  logic         out_valid, illegal;
  logic [N-1:0] S;
  logic [3:0]   COUT;

  typedef struct {
    logic [3:0]   alu;
    logic [1:0]   simd;
    logic         acc;
    logic         cin;
    logic [N-1:0] w, z, y, x;
    logic [N-1:0] s;
    logic [3:0]   cout;
    logic         ill;
    string        name;
  } vec_t;

  typedef struct {
    int           due;
    logic [N-1:0] s;
    logic [3:0]   cout;
    logic         ill;
    string        name;
  } exp_t;

  exp_t         sbq[$];
  exp_t         cur;
  vec_t         vecs[14];
  logic [3:0]   alus[6];
  logic [N-1:0] mp;
  logic [3:0]   mcout;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  logic         ev;

  simd_alu_pipelined_acc #(.LANES(4), .LANE_W(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .ALUMODE   (ALUMODE),
    .SIMD_MODE (SIMD_MODE),
    .ACC_EN    (ACC_EN),
    .CIN       (CIN),
    .W         (W),
    .Z         (Z),
    .Y         (Y),
    .X         (X),
    .out_valid (out_valid),
    .S         (S),
    .COUT      (COUT),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] rnd48();
    return N'({$urandom(), $urandom()});
  endfunction

  // Reference model: independent per-group arithmetic on 64-bit values
  function automatic void model(input logic [3:0] alu, input logic [1:0] simd, input logic acc,
                                input logic cin, input logic [N-1:0] w, z, y, x,
                                output logic [N-1:0] s, output logic [3:0] c, output logic il);
    longint unsigned gw, msk, sh, wg, zg, yg, xg, t, r, zl;
    int ng;
    s  = mp;
    c  = mcout;
    il = 1'b1;
    case (simd)
      2'b00:   ng = 1;
      2'b01:   ng = 2;
      2'b10:   ng = 4;
      default: ng = 0;
    endcase
    if (ng == 0) return;
    if (!(alu inside {4'b0000, 4'b0011, 4'b0100, 4'b1100, 4'b1101})) return;
    il  = 1'b0;
    s   = '0;
    c   = '0;
    gw  = 64'(N / 32'(ng));
    msk = (64'd1 << gw) - 64'd1;
    zl  = 64'(acc ? mp : z);
    for (int g = 0; g < ng; g++) begin
      sh = 64'(g) * gw;
      zg = (zl >> sh) & msk;
      wg = (64'(w) >> sh) & msk;
      yg = (64'(y) >> sh) & msk;
      xg = (64'(x) >> sh) & msk;
      r  = 64'd0;
      case (alu)
        4'b0000: begin
          t    = zg + wg + xg + yg + 64'(cin);
          r    = t & msk;
          c[g] = ((t >> gw) & 64'd1) != 64'd0;
        end
        4'b0011: begin
          t    = wg + xg + yg + 64'(cin);
          r    = (zg - t) & msk;
          c[g] = zg >= t;
        end
        4'b0100: r = xg ^ zg;
        4'b1100: r = xg & zg;
        default: r = xg | zg;
      endcase
      s = s | N'(r << sh);
    end
  endfunction

  task automatic drive(input logic [3:0] alu, input logic [1:0] simd, input logic acc, input logic cin,
                       input logic [N-1:0] w, z, y, x, input logic [N-1:0] es, input logic [3:0] ec,
                       input logic eil, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    ALUMODE   = alu;
    SIMD_MODE = simd;
    ACC_EN    = acc;
    CIN       = cin;
    W = w; Z = z; Y = y; X = x;
    e.due  = cyc + 2;
    e.s    = es;
    e.cout = ec;
    e.ill  = eil;
    e.name = nm;
    sbq.push_back(e);
    if (!eil) begin
      mp    = es;
      mcout = ec;
    end
  endtask

  task automatic send_model(input logic [3:0] alu, input logic [1:0] simd, input logic acc,
                            input logic cin, input logic [N-1:0] w, z, y, x, input string nm);
    logic [N-1:0] s;
    logic [3:0]   c;
    logic         il;
    model(alu, simd, acc, cin, w, z, y, x, s, c, il);
    drive(alu, simd, acc, cin, w, z, y, x, s, c, il, nm);
  endtask

  // Idle cycle with junk on the operand bus, which must not be captured
  task automatic idle();
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    ALUMODE   = 4'(($urandom));
    SIMD_MODE = 2'(($urandom));
    ACC_EN    = 1'b1;
    CIN       = 1'b1;
    W = rnd48(); Z = rnd48(); Y = rnd48(); X = rnd48();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    while (sbq.size() > 0 && sbq[sbq.size()-1].due > cyc) void'(sbq.pop_back());
    mp    = '0;
    mcout = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Output monitor: out_valid must match the scoreboard every cycle
  always @(negedge clk) begin
    ev = (sbq.size() > 0) && (sbq[0].due == cyc);
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev) begin
      cur = sbq.pop_front();
      chk({cur.name, ".S"}, 64'(S), 64'(cur.s));
      chk({cur.name, ".COUT"}, 64'(COUT), 64'(cur.cout));
      chk({cur.name, ".illegal"}, 64'(illegal), 64'(cur.ill));
    end
  end

  initial begin
    vecs[0]  = '{4'b0000, 2'b00, 1'b0, 1'b1, 48'd1, 48'd4, 48'd3, 48'd2, 48'd11, 4'b0000, 1'b0, "add_basic"};
    vecs[1]  = '{4'b0000, 2'b10, 1'b0, 1'b0, 48'd0, 48'h00FFFF000FFF, 48'd0, 48'd1, 48'h00FFFF000000, 4'b0001, 1'b0, "four_wrap"};
    vecs[2]  = '{4'b0011, 2'b01, 1'b0, 1'b0, 48'd0, 48'h000005000005, 48'h000001000009, 48'd0, 48'h000004FFFFFC, 4'b0010, 1'b0, "two_sub"};
    vecs[3]  = '{4'b0000, 2'b00, 1'b0, 1'b0, 48'd0, 48'hFFFFFFFFFFFF, 48'd0, 48'd1, 48'd0, 4'b0001, 1'b0, "one_full_carry"};
    vecs[4]  = '{4'b0011, 2'b00, 1'b0, 1'b0, 48'd5, 48'd5, 48'd0, 48'd0, 48'd0, 4'b0001, 1'b0, "sub_equal"};
    vecs[5]  = '{4'b0011, 2'b00, 1'b0, 1'b1, 48'd5, 48'd5, 48'd0, 48'd0, 48'hFFFFFFFFFFFF, 4'b0000, 1'b0, "sub_borrow_cin"};
    vecs[6]  = '{4'b0000, 2'b10, 1'b0, 1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFDFFDFFDFFD, 4'b1111, 1'b0, "four_add4"};
    vecs[7]  = '{4'b0100, 2'b00, 1'b0, 1'b1, 48'h123, 48'hFF00FF00FF00, 48'h456, 48'hF0F0F0F0F0F0, 48'h0FF00FF00FF0, 4'b0000, 1'b0, "xor"};
    vecs[8]  = '{4'b1100, 2'b01, 1'b0, 1'b0, 48'd0, 48'h0F0F0F0F0F0F, 48'd0, 48'h123456789ABC, 48'h020406080A0C, 4'b0000, 1'b0, "and"};
    vecs[9]  = '{4'b1101, 2'b10, 1'b0, 1'b0, 48'hFFF, 48'h000800000010, 48'd0, 48'h800000000001, 48'h800800000011, 4'b0000, 1'b0, "or"};
    vecs[10] = '{4'b0111, 2'b00, 1'b0, 1'b0, 48'd1, 48'd2, 48'd3, 48'd4, 48'h800800000011, 4'b0000, 1'b1, "ill_alu"};
    vecs[11] = '{4'b0000, 2'b11, 1'b0, 1'b0, 48'd1, 48'd2, 48'd3, 48'd4, 48'h800800000011, 4'b0000, 1'b1, "ill_simd"};
    vecs[12] = '{4'b0000, 2'b01, 1'b0, 1'b0, 48'd0, 48'h000000FFFFFF, 48'd0, 48'd1, 48'd0, 4'b0001, 1'b0, "two_wrap"};
    vecs[13] = '{4'b0011, 2'b10, 1'b0, 1'b0, 48'h001001001001, 48'h001002000003, 48'd0, 48'd0, 48'h000001FFF002, 4'b1101, 1'b0, "four_sub"};
    alus = '{4'b0000, 4'b0011, 4'b0100, 4'b1100, 4'b1101, 4'b0111};

    mp = '0; mcout = '0;
    reset = 1'b1; in_valid = 1'b0; ALUMODE = '0; SIMD_MODE = '0; ACC_EN = 1'b0; CIN = 1'b0;
    W = '0; Z = '0; Y = '0; X = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset.S", 64'(S), 64'd0);
    chk("reset.COUT", 64'(COUT), 64'd0);
    chk("reset.illegal", 64'(illegal), 64'd0);

    // Back-to-back table vectors, mode and op changing every beat
    for (int i = 0; i < 14; i++)
      drive(vecs[i].alu, vecs[i].simd, vecs[i].acc, vecs[i].cin, vecs[i].w, vecs[i].z,
            vecs[i].y, vecs[i].x, vecs[i].s, vecs[i].cout, vecs[i].ill, vecs[i].name);

    // Accumulate chain from reset, then hold while idle
    apply_reset();
    for (int i = 0; i < 5; i++) send_model(4'b0000, 2'b00, 1'b1, 1'b0, 48'd0, rnd48(), 48'd0, 48'd5, "acc_chain");
    idle();
    idle();
    @(negedge clk);
    chk("acc_last.S", 64'(S), 64'd25);
    for (int i = 0; i < 2; i++) begin
      idle();
      @(negedge clk);
      chk("acc_hold.S", 64'(S), 64'd25);
      chk("acc_hold.out_valid", 64'(out_valid), 64'd0);
    end
    send_model(4'b0111, 2'b00, 1'b0, 1'b0, 48'd1, 48'd2, 48'd3, 48'd4, "ill_after_acc");
    idle();

    // Reset while a beat sits in stage 1
    send_model(4'b0000, 2'b00, 1'b0, 1'b1, rnd48(), rnd48(), rnd48(), rnd48(), "killed_beat");
    apply_reset();
    @(negedge clk);
    chk("rst_flush.out_valid", 64'(out_valid), 64'd0);
    chk("rst_flush.S", 64'(S), 64'd0);
    chk("rst_flush.illegal", 64'(illegal), 64'd0);

    // Random mixed traffic with gaps
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send_model(alus[$urandom_range(0, 5)], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), rnd48(), rnd48(), rnd48(), rnd48(), "random");
    end
    idle();
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    chk("drain", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
